// File: rtl/layer_serializer.sv
// Collects one word per neuron from a parallel layer, then replays the frame
// serially (index 0 first, one word per cycle) to feed the next layer's input stream.
module layer_serializer #(
   parameter int NN        = 30,
   parameter int dataWidth = 16
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NN-1:0]           in_valid,
   input  logic [NN*dataWidth-1:0] in_data,
   output logic                    out_valid,
   output logic [dataWidth-1:0]    out_data,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun
);

   localparam int IDX_W = $clog2(NN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

   typedef enum logic {
      S_COLLECT,
      S_SEND
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [NN-1:0]         r_mask;
   logic [NN-1:0]         w_mask_next;
   logic                  w_mask_full;
   logic                  w_last;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_out_valid;
   logic [dataWidth-1:0]  r_out_data;
   logic                  r_frame_done;
   logic                  r_overrun;
   logic [dataWidth-1:0]  r_buf [NN];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Mask includes this cycle's captures so a frame completing in one cycle moves on at once.
   always_comb begin
      w_mask_next  = r_mask | in_valid;
      w_mask_full  = &w_mask_next;
      w_last       = (r_idx == LAST_IDX);
      w_state_next = r_state;
      case (r_state)
         S_COLLECT: if (w_mask_full) w_state_next = S_SEND;
         S_SEND:    if (w_last)      w_state_next = S_COLLECT;
         default:   w_state_next = S_COLLECT;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_mask       <= '0;
         r_idx        <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         case (r_state)
            S_COLLECT: begin
               r_mask       <= w_mask_full ? '0 : w_mask_next;
               r_out_valid  <= 1'b0;
               r_frame_done <= 1'b0;
            end
            S_SEND: begin
               r_out_valid  <= 1'b1;
               r_out_data   <= r_buf[r_idx];
               r_frame_done <= w_last;
               r_idx        <= w_last ? '0 : r_idx + 1'b1;
               // Words arriving mid-replay are dropped; only the sticky flag records them.
               if (|in_valid) r_overrun <= 1'b1;
            end
            default: begin
               r_out_valid  <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (r_state == S_COLLECT) begin
         for (int i = 0; i < NN; i++) begin
            if (in_valid[i]) r_buf[i] <= in_data[i*dataWidth +: dataWidth];
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;
   assign busy       = (r_state == S_SEND) || r_out_valid || (r_mask != '0);

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with NN=4, dataWidth=16; expected words are hand-written.
module tb_layer_serializer;

   localparam int NN = 4;
   localparam int DW = 16;

   logic              CLK;
   logic              RESET;
   logic [NN-1:0]     in_valid;
   logic [NN*DW-1:0]  in_data;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              busy;
   logic              frame_done;
   logic              overrun;

   int tests = 0;
   int fails = 0;
   logic exp_ov = 1'b0;

   layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at the negedge where the completing valids are driven; returns at the frame_done cycle.
   task automatic burst(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] w2, input logic [DW-1:0] w3, input int inj_k);
      logic [DW-1:0] w [NN];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      tick();
      in_valid = '0;
      check({tag, "_idle_vld"}, out_valid, 1'b0);
      check({tag, "_idle_busy"}, busy, 1'b1);
      for (int k = 0; k < NN; k++) begin
         tick();
         in_valid = '0;
         check($sformatf("%s_vld%0d", tag, k), out_valid, 1'b1);
         check($sformatf("%s_data%0d", tag, k), out_data, w[k]);
         check($sformatf("%s_fd%0d", tag, k), frame_done, (k == NN - 1));
         check($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
         check($sformatf("%s_ov%0d", tag, k), overrun, exp_ov);
         if (k == inj_k) begin
            in_valid = 4'b0010;
            in_data[1*DW +: DW] = 16'hDEAD;
            exp_ov = 1'b1;
         end
      end
   endtask

   initial begin
      RESET    = 1'b0;
      in_valid = '0;
      in_data  = '0;
      tick();
      tick();
      check("rst_vld", out_valid, 1'b0);
      check("rst_data", out_data, 16'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_fd", frame_done, 1'b0);
      check("rst_ov", overrun, 1'b0);
      RESET = 1'b1;
      tick();

      // All four valids in a single cycle
      in_valid = 4'b1111;
      in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      burst("t1", 16'h0001, 16'h0002, 16'h0003, 16'h0004, -1);
      tick();
      check("t1_after_vld", out_valid, 1'b0);
      check("t1_after_busy", busy, 1'b0);
      check("t1_after_fd", frame_done, 1'b0);
      check("t1_after_hold", out_data, 16'h0004);

      // Staggered valids
      in_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      in_valid = 4'b0001;
      tick();
      check("t2_busy1", busy, 1'b1);
      check("t2_vld1", out_valid, 1'b0);
      in_valid = 4'b0100;
      tick();
      check("t2_vld2", out_valid, 1'b0);
      in_valid = 4'b1000;
      tick();
      check("t2_vld3", out_valid, 1'b0);
      check("t2_busy3", busy, 1'b1);
      in_valid = 4'b0010;
      burst("t2", 16'h1000, 16'h1001, 16'h1002, 16'h1003, -1);
      tick();
      check("t2_after_busy", busy, 1'b0);

      // Neuron 2 reported twice: latest wins
      in_data  = {16'h2003, 16'h1111, 16'h2001, 16'h2000};
      in_valid = 4'b0100;
      tick();
      in_data  = {16'h2003, 16'h2222, 16'h2001, 16'h2000};
      in_valid = 4'b0100;
      tick();
      check("t3_vld", out_valid, 1'b0);
      in_data  = {16'h2003, 16'h3333, 16'h2001, 16'h2000};
      in_valid = 4'b1011;
      burst("t3", 16'h2000, 16'h2001, 16'h2222, 16'h2003, -1);
      tick();
      check("t3_ov", overrun, 1'b0);

      // Valid during replay sets the sticky overrun flag
      in_data  = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
      in_valid = 4'b1111;
      burst("t4", 16'h4000, 16'h4001, 16'h4002, 16'h4003, 0);
      tick();
      check("t4_ov_sticky", overrun, 1'b1);
      check("t4_after_busy", busy, 1'b0);
      in_data  = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
      in_valid = 4'b1101;
      tick();
      in_valid = '0;
      check("t4_partial_vld1", out_valid, 1'b0);
      check("t4_partial_busy", busy, 1'b1);
      tick();
      tick();
      check("t4_partial_vld2", out_valid, 1'b0);
      in_valid = 4'b0010;
      burst("t4b", 16'h5000, 16'h5001, 16'h5002, 16'h5003, -1);
      tick();
      check("t4b_ov", overrun, 1'b1);

      // Reset mid-frame abandons the partial frame
      in_data  = {16'h00EE, 16'h00EE, 16'h00EE, 16'h00EE};
      in_valid = 4'b0111;
      tick();
      in_valid = '0;
      RESET    = 1'b0;
      #1;
      check("t5_rst_ov", overrun, 1'b0);
      check("t5_rst_busy", busy, 1'b0);
      tick();
      RESET  = 1'b1;
      exp_ov = 1'b0;
      in_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
      in_valid = 4'b1000;
      tick();
      in_valid = '0;
      check("t5_no_stale1", out_valid, 1'b0);
      tick();
      check("t5_no_stale2", out_valid, 1'b0);
      in_valid = 4'b0111;
      burst("t5", 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, -1);
      tick();
      check("t5_after_busy", busy, 1'b0);

      // Back-to-back frames
      in_data  = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
      in_valid = 4'b1111;
      burst("t6a", 16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3, -1);
      tick();
      check("t6_gap_vld", out_valid, 1'b0);
      check("t6_gap_fd", frame_done, 1'b0);
      in_data  = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
      in_valid = 4'b1111;
      burst("t6b", 16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3, -1);
      tick();
      check("t6_after_busy", busy, 1'b0);
      check("t6_ov", overrun, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Inter-layer controller between a parallel neuron layer and the next layer's single-word input stream.
- Captures the NN outputs of one layer as each neuron's valid bit fires, and holds them until all NN have arrived.
- Then replays the words serially, index 0 first, one per cycle, on the x_valid/x_in-style stream that feeds every neuron of the next layer.
- Sequences back-to-back layers without external control.

Parameters:
- NN, 30, number of neurons in the producing layer (words per frame); >= 2.
- dataWidth, 16, bits per neuron output word.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- in_valid  input  NN  per-neuron output-valid pulses from the producing layer.
- in_data  input  NN*dataWidth  neuron outputs; neuron i at bits [i*dataWidth +: dataWidth].
- out_valid  output  1  serial word valid, feeds the next layer's x_valid.
- out_data  output  dataWidth  serial word, feeds the next layer's x_in.
- busy  output  1  high while a frame is being collected or sent.
- frame_done  output  1  one-cycle pulse coincident with the last serial word.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=COLLECT, capture mask=0, index=0.
  - out_valid=0, out_data=0, busy=0, frame_done=0, overrun=0.
  - Buffer contents are don't-care.
  - Reset mid-frame abandons the frame with no partial output.
- State COLLECT:
  - Each cycle, for every i with in_valid[i]=1: buffer[i] <= in_data slice i, mask[i] <= 1.
  - Re-assertion of an already-captured i overwrites its word (latest wins, no error).
  - busy = (mask != 0).
  - out_valid=0.
  - When the mask including this cycle's captures becomes all ones, go to SEND at the next edge. Mask clears on that transition.
  - All NN bits asserted in a single cycle is legal: capture and transition occur in that one cycle.
- State SEND:
  - out_valid=1 and out_data=buffer[index], registered outputs.
  - index increments 0..NN-1, one word per cycle, with no gaps.
  - busy=1.
  - frame_done=1 in the cycle index=NN-1. The following edge returns to COLLECT with index=0, out_valid=0, out_data held at its last value.
- Latency:
  - If the final missing valid is sampled at edge t, word 0 appears (out_valid=1) in the cycle after edge t+1.
  - Words 1..NN-1 follow in NN-1 consecutive cycles.
- Overrun:
  - Any in_valid bit asserted while in SEND sets overrun=1. Cleared only by RESET.
  - That data is discarded; the buffer and sent words are unaffected.
  - The mask is not updated, so the next frame must present all NN valids after SEND ends.
- Widths:
  - index width = $clog2(NN).
  - No arithmetic on data; words pass bit-exact.
- No backpressure: the downstream layer must accept one word per cycle whenever out_valid=1.

Test Plan:
- NN=4, dataWidth=16. All in_valid=4'b1111 in one cycle, words 0x0001,0x0002,0x0003,0x0004 -> after 1 idle cycle, out_valid high 4 consecutive cycles with out_data 0x0001,0x0002,0x0003,0x0004; frame_done high only on 0x0004; busy low afterwards.
- Staggered valids 4'b0001, 4'b0100, 4'b1000, 4'b0010 on 4 separate cycles -> busy high from the first; no output until the 4th; then 4-word burst in index order 0..3.
- Neuron 2 valid twice (0x1111, then 0x2222) before the frame completes -> word 2 sent = 0x2222; overrun=0.
- in_valid[1] pulsed during SEND cycle 2 -> overrun=1 and stays 1; burst unchanged; next frame still requires all 4 valids.
- RESET low for 1 cycle after 3 of 4 valids, then a full new frame 0xA0..0xA3 -> only 0xA0..0xA3 emitted; no stale words.
- Two frames back-to-back (second frame's valids arrive the cycle after frame_done) -> two correct 4-word bursts; overrun=0.
